// File: rtl/ctr163_seq_ctrl_if.sv
// Bundle between the sequencing controller, the 74x163 counter chain and the lab datapath.
// The slave side is the controller; the master side is the chain plus datapath.
interface ctr163_seq_ctrl_if #(
    parameter int W = 8
);
    logic         START;
    logic         ABORT;
    logic         HOLD;
    logic         PERIODIC;
    logic [W-1:0] PRESET;
    logic         CNT_RCO;
    logic         CNT_CLR_L;
    logic         CNT_LD_L;
    logic         CNT_ENP;
    logic         CNT_ENT;
    logic [W-1:0] CNT_D;
    logic         BUSY;
    logic         TICK;
    logic         DONE;

    modport slave (
        input  START, ABORT, HOLD, PERIODIC, PRESET, CNT_RCO,
        output CNT_CLR_L, CNT_LD_L, CNT_ENP, CNT_ENT, CNT_D, BUSY, TICK, DONE
    );

    modport master (
        output START, ABORT, HOLD, PERIODIC, PRESET, CNT_RCO,
        input  CNT_CLR_L, CNT_LD_L, CNT_ENP, CNT_ENT, CNT_D, BUSY, TICK, DONE
    );
endinterface

// File: rtl/ctr163_seq_ctrl.sv
// Interval timer controller for a cascaded 74x163 chain: clears, loads and enables the
// chain, watches its final RCO and reports BUSY/TICK/DONE.
module ctr163_seq_ctrl #(
    parameter int W = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    ctr163_seq_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE} state_t;

    state_t       state, state_n;
    logic [W-1:0] pr;
    logic         pr_ld;
    logic         tick, tick_n;
    logic         term;
    logic         clr_l, ld_l, enp, ent;

    // Terminal count only counts while the chain is actually allowed to advance.
    assign term = bus.CNT_RCO & ~bus.HOLD;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            pr    <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            if (pr_ld) pr <= bus.PRESET;
        end
    end

    always_comb begin
        state_n = state;
        pr_ld   = 1'b0;
        tick_n  = 1'b0;
        clr_l   = 1'b1;
        ld_l    = 1'b1;
        enp     = 1'b0;
        ent     = 1'b0;

        case (state)
            S_CLEAR: clr_l = 1'b0;
            S_LOAD:  ld_l  = 1'b0;
            S_RUN: begin
                ent = 1'b1;
                enp = ~bus.HOLD;
                // Periodic reload replaces the wrap at terminal count.
                if (term && bus.PERIODIC) ld_l = 1'b0;
            end
            default: ;
        endcase

        if (bus.ABORT) begin
            state_n = S_CLEAR;
        end else begin
            case (state)
                S_IDLE, S_CLEAR, S_LOAD, S_DONE: begin
                    if (bus.START) begin
                        pr_ld   = 1'b1;
                        state_n = S_LOAD;
                    end else if (state == S_CLEAR) begin
                        state_n = S_IDLE;
                    end else if (state == S_LOAD) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.START) begin
                        // Restart wins over a pending terminal count; no TICK.
                        pr_ld   = 1'b1;
                        state_n = S_LOAD;
                    end else if (term) begin
                        tick_n = 1'b1;
                        if (!bus.PERIODIC) state_n = S_DONE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.CNT_CLR_L = clr_l;
    assign bus.CNT_LD_L  = ld_l;
    assign bus.CNT_ENP   = enp;
    assign bus.CNT_ENT   = ent;
    assign bus.CNT_D     = pr;
    assign bus.BUSY      = (state == S_LOAD) || (state == S_RUN);
    assign bus.DONE      = (state == S_DONE);
    assign bus.TICK      = tick;
endmodule

// File: doc/ctr163_seq_ctrl.md
Name: ctr163_seq_ctrl

Overview:
- Sequencing controller for a chain of 74x163-style 4-bit synchronous counters cascaded to W bits (RCO to ENT ripple).
- Drives the chain's CLR_L, LD_L, ENP, ENT and D pins to form a programmable interval timer, one-shot or periodic.
- Takes the chain's final RCO back and reports status (BUSY, TICK, DONE) to the surrounding lab datapath.

Parameters:
- W, 8, total counter chain width in bits; must be a multiple of 4 (8 = two cascaded counters).

Ports:
- CLK  in  1  system clock; every flop on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  start/restart request, sampled at the edge.
- ABORT  in  1  stop and clear the chain, sampled at the edge.
- HOLD  in  1  pause counting while high.
- PERIODIC  in  1  1 = auto-reload at terminal count; 0 = one-shot.
- PRESET  in  W  start value, latched on an accepted START.
- CNT_RCO  in  1  ripple carry out of the last chain stage (Q all ones AND ENT).
- CNT_CLR_L  out  1  synchronous clear to the chain, active low.
- CNT_LD_L  out  1  synchronous load to the chain, active low.
- CNT_ENP  out  1  count enable P, common to all stages.
- CNT_ENT  out  1  count enable T, to the first stage only.
- CNT_D  out  W  load data; equals the latched preset register PR.
- BUSY  out  1  high in LOAD and RUN.
- TICK  out  1  registered one-cycle pulse after each terminal count.
- DONE  out  1  high in DONE state.

Behaviour:
- Reset is async: state = IDLE, PR = 0, TICK = 0.
  - Chain outputs during and after reset: CLR_L=1, LD_L=1, ENP=0, ENT=0, D=0.
  - BUSY=0, DONE=0.
- States are IDLE, CLEAR, LOAD, RUN, DONE. Chain outputs decode combinationally from state plus inputs.
  - Default for any pin not listed: CLR_L=1, LD_L=1, ENP=0, ENT=0.
- Input priority at every edge: ABORT > START > HOLD.
- ABORT, from any state: next state is CLEAR; TICK is forced to 0 next cycle.
- CLEAR: CLR_L=0 for exactly one cycle, so the chain reads 0 after the edge.
  - Next state is IDLE, or LOAD if START is high that cycle.
- IDLE: on START, latch PR <= PRESET and go to LOAD.
- LOAD: LD_L=0 and D=PR for one cycle; the chain reads PR after the edge; next state is RUN.
- RUN: ENT=1; ENP = ~HOLD.
  - Terminal condition T = CNT_RCO & ~HOLD.
  - T with PERIODIC=1: drive LD_L=0 in the same cycle, so the chain reloads PR at the edge instead of wrapping; stay in RUN.
  - T with PERIODIC=0: the chain wraps to 0 at the edge (ENP=1); next state is DONE.
  - TICK is set to 1 in the cycle after any T; otherwise TICK is 0.
  - HOLD=1 freezes the chain, including at terminal count; no TICK is produced while held.
- Period: 2^W − PR cycles between TICKs. PR = 0 gives the full 2^W.
  - PR = all-ones: T on every RUN cycle, so TICK is continuously high in periodic mode.
- DONE: all enables are 0; DONE=1; the chain holds 0.
  - START latches a new PR and goes to LOAD.
- START in RUN or LOAD (ABORT low): restart. Re-latch PR and go to LOAD; the reload overrides any pending T, and no TICK is produced.
- PERIODIC and PRESET may change freely. PRESET matters only on an accepted START. PERIODIC is sampled on each T.
- RESET asserted mid-run: outputs return to their reset values immediately (asynchronous), and the chain stops counting at the next edge.

Test Plan:
- Reset release, then idle 5 cycles -> all chain pins idle (CLR_L=1, LD_L=1, ENP=0, ENT=0), BUSY=0, DONE=0, TICK=0.
- W=8, PRESET=0xFA, PERIODIC=1, START pulse -> LD_L low 1 cycle with D=0xFA; chain counts FA..FF repeatedly; TICK every 6 cycles, first TICK 7 cycles after the LOAD cycle.
- PRESET=0xFD, PERIODIC=0 -> BUSY for 1+3 cycles, one TICK, then DONE=1, ENP=0, chain holds 0x00.
- Periodic run with PRESET=0xFA, HOLD high 4 cycles while the chain is at 0xFF -> chain stays 0xFF, no TICK; TICK follows 1 cycle after HOLD falls; later periods remain 6.
- ABORT during RUN with the chain at 0xFC -> CLR_L low 1 cycle, chain reads 0x00, IDLE, TICK=0; START together with ABORT -> CLEAR then LOAD.
- RESET pulse mid-RUN (async, between edges) -> outputs at reset values before the next edge; PRESET=0x00 then START -> TICK period 256.
